// File: rtl/oam_dma.sv
// OAM DMA engine with FF46 source register and 127-byte HRAM, arbitrating CPU vs DMA on the memory bus.
// Optional OAM_DMA_ECHO_EN: source pages E0-FF are fetched from the WRAM they mirror (src-20).
module oam_dma #(
   parameter int unsigned DMA_LEN     = 160,
   parameter int unsigned START_DELAY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [15:0] mem_a,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        dma_active
);

   localparam int unsigned HRAM_DEPTH = 127;
   localparam int unsigned CNT_W      = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam logic [7:0]       LAST_IDX = 8'(DMA_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_DELAY - 1);

   typedef enum logic [1:0] {IDLE, START, XFER} state_t;

   state_t           state, state_n;
   logic [7:0]       src, src_n;
   logic [7:0]       idx, idx_n;
   logic [1:0]       phase, phase_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             wr_q;
   logic             act_n;
   logic [15:0]      mem_a_n;
   logic [7:0]       mem_dout_n;
   logic             mem_rd_n, mem_wr_n;
   logic [7:0]       din_n;

   logic [7:0] hram [HRAM_DEPTH];

   logic wr_ev, is_hram, is_reg, trig;

   assign wr_ev   = cpu_wr & ~wr_q;
   assign is_hram = (cpu_a >= 16'hFF80) && (cpu_a != 16'hFFFF);
   assign is_reg  = (cpu_a == 16'hFF46);
   assign trig    = wr_ev & is_reg;

   // Source page actually driven on the bus for a given FF46 value.
   function automatic logic [7:0] fetch_page(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_EN
      return (s >= 8'hE0) ? 8'(s - 8'h20) : s;
`else
      return s;
`endif
   endfunction

   // Next-state and next-output logic; bus outputs reflect the state being entered.
   always_comb begin
      state_n    = state;
      src_n      = src;
      idx_n      = idx;
      phase_n    = phase;
      cnt_n      = cnt;
      act_n      = dma_active;
      mem_a_n    = cpu_a;
      mem_dout_n = cpu_dout;
      mem_rd_n   = 1'b0;
      mem_wr_n   = 1'b0;
      din_n      = 8'hFF;

      if (trig) begin
         src_n   = cpu_dout;
         state_n = START;
         cnt_n   = '0;
         phase_n = 2'd0;
         idx_n   = 8'd0;
         act_n   = 1'b1;
      end else begin
         case (state)
            START: begin
               if (cnt == CNT_LAST) begin
                  state_n = XFER;
                  phase_n = 2'd0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            XFER: begin
               if (phase == 2'd3) begin
                  phase_n = 2'd0;
                  idx_n   = idx + 8'd1;
                  if (idx == LAST_IDX) begin
                     state_n = IDLE;
                     act_n   = 1'b0;
                  end
               end else begin
                  phase_n = phase + 2'd1;
               end
            end
            default: ;
         endcase
      end

      case (state_n)
         IDLE: begin
            if (!is_hram && !is_reg) begin
               mem_rd_n = cpu_rd;
               mem_wr_n = cpu_wr;
            end
         end
         XFER: begin
            case (phase_n)
               2'd0, 2'd1: begin
                  mem_a_n  = {fetch_page(src_n), idx_n};
                  mem_rd_n = 1'b1;
               end
               2'd2: mem_a_n = {fetch_page(src_n), idx_n};
               default: begin
                  // p3 is only entered from p2, so mem_din here is the fetched byte.
                  mem_a_n    = {8'hFE, idx_n};
                  mem_dout_n = mem_din;
                  mem_wr_n   = 1'b1;
               end
            endcase
         end
         default: ;
      endcase

      if (is_hram)         din_n = hram[cpu_a[6:0]];
      else if (is_reg)     din_n = src;
      else if (!dma_active) din_n = mem_din;
   end

   // HRAM storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ev && is_hram) hram[cpu_a[6:0]] <= cpu_dout;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         src        <= 8'h00;
         idx        <= 8'h00;
         phase      <= 2'd0;
         cnt        <= '0;
         wr_q       <= 1'b0;
         dma_active <= 1'b0;
         mem_a      <= 16'h0000;
         mem_dout   <= 8'h00;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         cpu_din    <= 8'hFF;
      end else begin
         state      <= state_n;
         src        <= src_n;
         idx        <= idx_n;
         phase      <= phase_n;
         cnt        <= cnt_n;
         wr_q       <= cpu_wr;
         dma_active <= act_n;
         mem_a      <= mem_a_n;
         mem_dout   <= mem_dout_n;
         mem_rd     <= mem_rd_n;
         mem_wr     <= mem_wr_n;
         cpu_din    <= din_n;
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: idle vector table plus DMA copy, blocking, retrigger, reset and echo sequences.
module tb_oam_dma;

   localparam int RUN_LEN = 4 + 4 * 160;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cpu_a = 16'h0000;
   logic [7:0]  cpu_dout = 8'h00;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_din, mem_dout, mem_din;
   logic [15:0] mem_a;
   logic        mem_rd, mem_wr, dma_active;

   int checks = 0;
   int errors = 0;
   int pcnt = 0;
   int overlap = 0;
   int c100_hits = 0;

   logic [7:0] mem [65536];
   bit         valid [65536];

   typedef struct {
      logic [15:0] a;
      logic [7:0]  dout;
      logic        rd;
      logic        wr;
      logic        e_rd;
      logic        e_wr;
      logic [7:0]  e_din;
   } vec_t;

   vec_t tbl [8];

   oam_dma dut (
      .clk(clk), .rst(rst),
      .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .dma_active(dma_active)
   );

   // Power-on memory image: C0 page = low byte, D0 page = low byte + 40.
   function automatic logic [7:0] init_val(input logic [15:0] a);
      if (a >= 16'hC000 && a < 16'hC0A0) return a[7:0];
      if (a >= 16'hD000 && a < 16'hD0A0) return 8'(a[7:0] + 8'h40);
      case (a)
         16'h8000: return 8'h11;
         16'h4000: return 8'h22;
         16'h1234: return 8'h42;
         16'hFFFF: return 8'h77;
         default:  return a[7:0] ^ a[15:8];
      endcase
   endfunction

   assign mem_din = valid[mem_a] ? mem[mem_a] : init_val(mem_a);

   always #5 clk = ~clk;

   always @(posedge clk) pcnt <= pcnt + 1;

   always @(negedge clk) begin
      if (mem_wr) begin
         mem[mem_a]   <= mem_dout;
         valid[mem_a] <= 1'b1;
         if (mem_a == 16'hC100) c100_hits++;
      end
      if (mem_rd && mem_wr) overlap++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fire(input logic [7:0] v, output int t0);
      cpu_a = 16'hFF46; cpu_dout = v; cpu_wr = 1'b1; cpu_rd = 1'b0;
      t0 = pcnt;
      @(negedge clk);
      cpu_wr = 1'b0; cpu_a = 16'h0000;
   endtask

   task automatic find_first(input bit want_wr, output logic [15:0] a, output logic [7:0] d, output int t);
      int i;
      i = 0;
      while (!(want_wr ? mem_wr : mem_rd) && i < 100) begin
         @(negedge clk);
         i++;
      end
      if (i >= 100) chk("strobe_wait", 16'(i), 16'(0));
      a = mem_a; d = mem_dout; t = pcnt;
   endtask

   task automatic wait_idle(input int t0, output int len);
      int i;
      i = 0;
      while (dma_active && i < 3000) begin
         @(negedge clk);
         i++;
      end
      if (i >= 3000) chk("idle_wait", 16'(i), 16'(0));
      len = pcnt - t0 - 1;
   endtask

   task automatic chk_copy(input string name, input logic [7:0] ofs);
      for (int i = 0; i < 160; i++)
         chk(name, 16'(mem[16'hFE00 + 16'(i)]), 16'(8'(i) + ofs));
      chk({name, "_tail"}, 16'(valid[16'hFEA0]), 16'(0));
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  d;
      int t0, t, len, n;

      tbl[0] = '{16'h8000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};
      tbl[1] = '{16'hFF80, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
      tbl[2] = '{16'hFF80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A};
      tbl[3] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4] = '{16'hFFFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77};
      tbl[5] = '{16'hFFFE, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3};
      tbl[6] = '{16'h4000, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
      tbl[7] = '{16'hFF7F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80};

      // Reset values
      #12;
      chk("rst_active", 16'(dma_active), 16'(0));
      chk("rst_mem_rd", 16'(mem_rd), 16'(0));
      chk("rst_mem_wr", 16'(mem_wr), 16'(0));
      chk("rst_mem_a", mem_a, 16'h0000);
      chk("rst_mem_dout", 16'(mem_dout), 16'h0000);
      chk("rst_cpu_din", 16'(cpu_din), 16'h00FF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Idle passthrough / HRAM / FF46 vector table
      for (int k = 0; k < 8; k++) begin
         cpu_a = tbl[k].a; cpu_dout = tbl[k].dout;
         cpu_rd = tbl[k].rd; cpu_wr = tbl[k].wr;
         @(negedge clk);
         chk($sformatf("vec%0d_mem_a", k), mem_a, tbl[k].a);
         chk($sformatf("vec%0d_mem_rd", k), 16'(mem_rd), 16'(tbl[k].e_rd));
         chk($sformatf("vec%0d_mem_wr", k), 16'(mem_wr), 16'(tbl[k].e_wr));
         @(negedge clk);
         chk($sformatf("vec%0d_cpu_din", k), 16'(cpu_din), 16'(tbl[k].e_din));
         cpu_rd = 1'b0; cpu_wr = 1'b0;
         @(negedge clk);
      end

      // Level write held 3 clocks: mem_wr follows, HRAM takes a single write
      cpu_a = 16'h8000; cpu_dout = 8'h3C; cpu_wr = 1'b1; n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (mem_wr) begin
            n++;
            chk("pass_dout", 16'(mem_dout), 16'h003C);
         end
         if (k == 2) cpu_wr = 1'b0;
      end
      chk("pass_wr_count", 16'(n), 16'(3));
      cpu_a = 16'hFF80; cpu_dout = 8'h3C; cpu_wr = 1'b1;
      @(negedge clk);
      cpu_dout = 8'h99;
      @(negedge clk);
      @(negedge clk);
      chk("hram_no_fwd", 16'(mem_wr), 16'(0));
      cpu_wr = 1'b0; cpu_rd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("hram_one_write", 16'(cpu_din), 16'h003C);
      cpu_rd = 1'b0;
      @(negedge clk);

      // Basic copy from C000 with CPU blocking checks mid-transfer
      fire(8'hC0, t0);
      find_first(1'b0, a, d, t);
      chk("copy_first_rd_a", a, 16'hC000);
      chk("copy_start_gap", 16'(t - t0), 16'(5));
      find_first(1'b1, a, d, t);
      chk("copy_first_wr_a", a, 16'hFE00);
      chk("copy_first_wr_d", 16'(d), 16'h0000);
      cpu_a = 16'h1234; cpu_rd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("blk_read", 16'(cpu_din), 16'h00FF);
      cpu_rd = 1'b0; cpu_a = 16'hC100; cpu_dout = 8'h55; cpu_wr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      cpu_wr = 1'b0;
      @(negedge clk);
      cpu_a = 16'hFF90; cpu_dout = 8'hA5; cpu_wr = 1'b1;
      @(negedge clk);
      cpu_wr = 1'b0; cpu_rd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("blk_hram_rd", 16'(cpu_din), 16'h00A5);
      chk("blk_still_active", 16'(dma_active), 16'(1));
      cpu_rd = 1'b0; cpu_a = 16'h0000;
      wait_idle(t0, len);
      chk("copy_len", 16'(len), 16'(RUN_LEN));
      chk_copy("copy_c0", 8'h00);
      chk("blk_c100", 16'(c100_hits), 16'(0));
      @(negedge clk);

      // Retrigger at idx 10 with a new source page
      fire(8'hC0, t0);
      n = 0;
      while (!(mem_wr && mem_a == 16'hFE0A) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("retrig_reach_idx10", 16'(n < 200), 16'(1));
      fire(8'hD0, t0);
      find_first(1'b0, a, d, t);
      chk("retrig_rd_a", a, 16'hD000);
      chk("retrig_gap", 16'(t - t0), 16'(5));
      find_first(1'b1, a, d, t);
      chk("retrig_wr_a", a, 16'hFE00);
      chk("retrig_wr_d", 16'(d), 16'h0040);
      wait_idle(t0, len);
      chk("retrig_len", 16'(len), 16'(RUN_LEN));
      chk_copy("copy_d0", 8'h40);
      @(negedge clk);

      // Asynchronous reset during a p3 write, then a clean restart
      fire(8'hC0, t0);
      find_first(1'b1, a, d, t);
      rst = 1'b0;
      #1;
      chk("arst_mem_wr", 16'(mem_wr), 16'(0));
      chk("arst_active", 16'(dma_active), 16'(0));
      chk("arst_mem_a", mem_a, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      fire(8'hC0, t0);
      find_first(1'b0, a, d, t);
      chk("arst_restart_rd_a", a, 16'hC000);
      chk("arst_restart_gap", 16'(t - t0), 16'(5));
      find_first(1'b1, a, d, t);
      chk("arst_restart_wr_a", a, 16'hFE00);
      wait_idle(t0, len);
      chk("arst_len", 16'(len), 16'(RUN_LEN));
      chk_copy("copy_after_rst", 8'h00);
      @(negedge clk);

      // Echo page source
      fire(8'hE0, t0);
      find_first(1'b0, a, d, t);
`ifdef OAM_DMA_ECHO_EN
      chk("echo_rd_a", a, 16'hC000);
`else
      chk("echo_rd_a", a, 16'hE000);
`endif
      cpu_a = 16'hFF46; cpu_rd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("echo_ff46_rd", 16'(cpu_din), 16'h00E0);
      cpu_rd = 1'b0; cpu_a = 16'h0000;
      wait_idle(t0, len);
      chk("echo_len", 16'(len), 16'(RUN_LEN));

      chk("no_rd_wr_overlap", 16'(overlap), 16'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
